im_loader: RTL

Boot-time writer for the 1024-word instruction memory, which is read combinationally by word index `PC[11:2]`. It accepts a byte stream over a valid/ready handshake and packs each group of four bytes big-endian into a 32-bit word. It issues one write per word at consecutive word addresses starting at 0, and holds the CPU in reset until loading finishes. It sits between the host/UART byte source and the IM write port, on the same clock as the CPU.

---
 rtl/im_loader_pkg.sv | 11 +
 rtl/im_loader_byte_packer.sv | 28 ++
 rtl/im_loader.sv | 94 +++++++++
 3 files changed

// File: rtl/im_loader_pkg.sv
// im_loader_pkg: loader FSM encodings and instruction-memory geometry shared with the IM.
package im_loader_pkg;
  localparam int IM_ADDR_W = 10;
  localparam int IM_DEPTH  = 1 << IM_ADDR_W;
  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_RECV  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_t;
endpackage

// File: rtl/im_loader_byte_packer.sv
// im_loader_byte_packer: big-endian 4-byte shift register with byte index, clear and load enable.
module im_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic [1:0]  o_idx
);
  logic [31:0] r_word;
  logic [1:0]  r_idx;
  // ~idx selects lane 3-idx, so byte 0 lands in [31:24]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_word[{~r_idx, 3'b000} +: 8] <= i_data;
      r_idx                         <= r_idx + 2'd1;
    end
  end
  assign o_word = r_word;
  assign o_idx  = r_idx;
endmodule

// File: rtl/im_loader.sv
// im_loader: packs a boot byte stream into 32-bit words and writes them to IM from address 0,
// holding the CPU in reset while a load is in progress.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);
  ld_state_t         r_state, w_next;
  logic              r_last, r_done, r_err;
  logic [ADDR_W:0]   r_count;
  logic              w_go, w_acc, w_end, w_full, w_fin;
  logic [31:0]       w_word;
  logic [1:0]        w_idx;

  assign w_go   = start && (r_state == LD_IDLE || r_state == LD_DONE);
  assign w_acc  = in_valid && r_state == LD_RECV;
  assign w_end  = w_acc && (w_idx == 2'd3 || in_last);
  // count is below capacity inside WRITE, so all-ones low bits means this is the last slot
  assign w_full = &r_count[ADDR_W-1:0];
  assign w_fin  = r_last || w_full;

  im_loader_byte_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_go || r_state == LD_WRITE),
    .i_load (w_acc),
    .i_data (in_data),
    .o_word (w_word),
    .o_idx  (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LD_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LD_IDLE, LD_DONE: w_next = start ? LD_RECV : r_state;
      LD_RECV:          w_next = w_end ? LD_WRITE : LD_RECV;
      LD_WRITE:         w_next = w_fin ? LD_DONE : LD_RECV;
      default:          w_next = LD_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = r_state == LD_RECV;
    we           = r_state == LD_WRITE;
    busy         = r_state == LD_RECV || r_state == LD_WRITE;
    cpu_hold     = busy;
    waddr        = r_count[ADDR_W-1:0];
    wdata        = we ? w_word : 32'd0;
    done         = r_done;
    err_overflow = r_err;
    word_count   = r_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else if (w_go) begin
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else if (w_acc) begin
      r_last <= in_last;
    end else if (r_state == LD_WRITE) begin
      r_count <= r_count + 1'b1;
      r_done  <= w_fin;
      r_err   <= !r_last && w_full;
    end
  end
endmodule
